writeback_block: RTL
====================

WRITEBACK_BLOCK -- requirements
Module: writeback_block

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 SHALL expose: clk_i  in  1  clock, all state updates on rising edge.
REQ-003 SHALL expose: reset_i  in  1  synchronous active-high reset.
REQ-004 SHALL expose: stall_i  in  1  hold stage register, suppress repeat writes.
REQ-005 SHALL expose: flush_i  in  1  load a bubble instead of inputs.
REQ-006 SHALL expose: reg_file_write_en_i  in  reg_file_write_sig  instruction writes a register.
REQ-007 SHALL expose: reg_file_input_ctrl_sig_i  in  reg_file_data_source  ALU or memory result.
REQ-008 SHALL expose: reg_dest_addr_i  in  ADDR_WIDTH  destination register.
REQ-009 SHALL expose: alu_result_i, mem_data_i  in  WORD each  candidate results; mem_data_i is the raw aligned word.
REQ-010 SHALL expose: mem_access_size_i  in  mem_access_size  byte/half/word; mem_signed_i  in  1  sign-extend loads.
REQ-011 SHALL expose: mem_addr_low_i  in  2  byte offset of the load address.
REQ-012 SHALL expose: reg_file_write_en_o  out  1; reg_dest_addr_o  out  ADDR_WIDTH; reg_data_o  out  WORD; these are the decode-stage register-file write port.
REQ-013 SHALL expose: fwd_valid_o  out  1; fwd_addr_o  out  ADDR_WIDTH; fwd_data_o  out  WORD; the previous-cycle write, for decode bypass.

Function
REQ-014 SHALL capture all inputs into a stage register on each rising edge when stall_i=0; latency is one cycle from input to write port.
REQ-015 SHALL load a bubble (write enable cleared, address and data unchanged) when flush_i=1; flush_i overrides stall_i.
REQ-016 SHALL select reg_data_o combinationally from the registered values: the ALU result, or the extended memory data.
REQ-017 SHALL extract the byte lane mem_addr_low_i (little-endian) for byte loads, and the halfword selected by mem_addr_low_i[1] for half loads; mem_addr_low_i[0] SHALL be ignored for half loads.
REQ-018 SHALL sign-extend byte and half loads when mem_signed_i=1, otherwise zero-extend; word loads SHALL pass unchanged.
REQ-019 SHALL assert reg_file_write_en_o for exactly one cycle per captured writing instruction; a committed flag SHALL suppress it while stall_i holds the same entry.
REQ-020 SHALL clear the committed flag when a new entry is captured.
REQ-021 SHALL drive fwd_valid_o/fwd_addr_o/fwd_data_o from a history register loaded with the write port values in every cycle in which reg_file_write_en_o=1; fwd_valid_o SHALL fall the cycle after a cycle with no write.
REQ-022 SHALL NOT gate writes to any destination address, including register 15.

Reset
REQ-023 SHALL force, while reset_i=1 at a clock edge: stage register to bubble, committed flag 0, history invalid; all outputs read 0 on the following cycle.
REQ-024 SHALL discard any in-flight entry on a reset mid-stall; no write SHALL occur for it afterwards.

Configuration
REQ-025 SHALL implement the history/forward path only when WB_FORWARD_HISTORY_EN is defined; when it is not defined, fwd_valid_o, fwd_addr_o and fwd_data_o SHALL be constant 0 and no history register SHALL exist.

Structure
REQ-026 SHALL take WORD, ADDR_WIDTH, reg_file_write_sig, reg_file_data_source and the new mem_access_size enum (BYTE, HALF, FULL_WORD) from the shared definitions package.
REQ-027 SHALL place load alignment and extension in one combinational sub-module, load_extender.

Verification
REQ-028 SHALL cover: write ALU result 0x0000_1234 to r3 -> one cycle later write_en=1, addr=3, data=0x0000_1234 for exactly one cycle.
REQ-029 SHALL cover: memory word 0x80F0_7F81, signed byte, offset 3 -> 0xFFFF_FF80; unsigned half, offset 2 -> 0x0000_80F0; signed byte, offset 0 -> 0xFFFF_FF81.
REQ-030 SHALL cover: capture a write, then hold stall_i=1 for 3 cycles -> write_en high exactly once; the next entry is captured after stall_i falls.
REQ-031 SHALL cover: flush_i=1 together with stall_i=1 and a writing instruction -> bubble, no write_en.
REQ-032 SHALL cover: reset asserted during a stall with an uncommitted write -> no write ever issued; all outputs 0.
REQ-033 SHALL cover: with WB_FORWARD_HISTORY_EN, back-to-back writes to r1 then r2 -> in the second cycle fwd_addr_o=1 and fwd_data_o=the r1 data; without the macro the fwd outputs are always 0.

Source files
------------

// File: rtl/writeback_block_pkg.sv
// ---------------------------------------------------------------------------
// writeback_block_pkg
// The definitions shared by the writeback stage. The testbench uses them too.
//   WORD                 : register-file data word
//   ADDR_WIDTH           : register address width (16 registers)
//   reg_file_write_sig   : whether an instruction writes a register
//   reg_file_data_source : whether the result comes from the ALU or from memory
//   mem_access_size      : load width (BYTE, HALF, FULL_WORD)
//   wb_stage_t           : contents of the writeback stage register
// ---------------------------------------------------------------------------
package writeback_block_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int ADDR_WIDTH = 4;

    typedef logic [WORD_WIDTH-1:0] WORD;

    typedef enum logic {
        WRITE_DISABLE = 1'b0,
        WRITE_ENABLE  = 1'b1
    } reg_file_write_sig;

    typedef enum logic {
        FROM_ALU = 1'b0,
        FROM_MEM = 1'b1
    } reg_file_data_source;

    typedef enum logic [1:0] {
        BYTE      = 2'd0,
        HALF      = 2'd1,
        FULL_WORD = 2'd2
    } mem_access_size;

    typedef struct packed {
        reg_file_write_sig   we;
        reg_file_data_source src;
        logic [ADDR_WIDTH-1:0] addr;
        WORD                 alu;
        WORD                 mem;
        mem_access_size      size;
        logic                sgn;
        logic [1:0]          low;
    } wb_stage_t;

endpackage

// File: rtl/writeback_block_load_extender.sv
// ---------------------------------------------------------------------------
// load_extender
// This is a combinational block. It aligns a load and extends it to a full word.
//   mem_data_i (WORD)       : raw aligned memory word
//   size_i (mem_access_size): BYTE / HALF / FULL_WORD
//   signed_i                : sign-extend when 1, zero-extend when 0
//   addr_low_i [1:0]        : byte offset of the load (little-endian)
//   data_o (WORD)           : extended load result
// For half loads, only addr_low_i[1] selects the halfword.
// ---------------------------------------------------------------------------
module load_extender
    import writeback_block_pkg::*;
(
    input  WORD            mem_data_i,
    input  mem_access_size size_i,
    input  logic           signed_i,
    input  logic [1:0]     addr_low_i,
    output WORD            data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_data_i[7:0];
        case (addr_low_i)
            2'd0: byte_sel = mem_data_i[7:0];
            2'd1: byte_sel = mem_data_i[15:8];
            2'd2: byte_sel = mem_data_i[23:16];
            2'd3: byte_sel = mem_data_i[31:24];
            default: byte_sel = mem_data_i[7:0];
        endcase
        half_sel = addr_low_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    end

    always_comb begin
        data_o = mem_data_i;
        case (size_i)
            BYTE:    data_o = {{(WORD_WIDTH-8){signed_i & byte_sel[7]}}, byte_sel};
            HALF:    data_o = {{(WORD_WIDTH-16){signed_i & half_sel[15]}}, half_sel};
            default: data_o = mem_data_i;
        endcase
    end

endmodule

// File: rtl/writeback_block.sv
// ---------------------------------------------------------------------------
// writeback_block
// This is the pipeline writeback stage. It drives the decode-stage register-file
// write port.
// Optional feature: when WB_FORWARD_HISTORY_EN is defined, a history register
// of last cycle's write drives fwd_*_o. Otherwise fwd_*_o are tied to 0.
// Ports:
//   clk_i, reset_i           : clock and synchronous active-high reset
//   stall_i                  : hold the stage register
//   flush_i                  : load a bubble; takes priority over stall_i
//   reg_file_write_en_i      : instruction writes a register
//   reg_file_input_ctrl_sig_i: select ALU or memory result
//   reg_dest_addr_i          : destination register
//   alu_result_i, mem_data_i : candidate results
//   mem_access_size_i, mem_signed_i, mem_addr_low_i : load shaping
//   reg_file_write_en_o, reg_dest_addr_o, reg_data_o: register-file write port
//   fwd_valid_o, fwd_addr_o, fwd_data_o             : previous-cycle write
// ---------------------------------------------------------------------------
module writeback_block
    import writeback_block_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  reg_file_write_sig     reg_file_write_en_i,
    input  reg_file_data_source   reg_file_input_ctrl_sig_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_addr_i,
    input  WORD                   alu_result_i,
    input  WORD                   mem_data_i,
    input  mem_access_size        mem_access_size_i,
    input  logic                  mem_signed_i,
    input  logic [1:0]            mem_addr_low_i,
    output logic                  reg_file_write_en_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_addr_o,
    output WORD                   reg_data_o,
    output logic                  fwd_valid_o,
    output logic [ADDR_WIDTH-1:0] fwd_addr_o,
    output WORD                   fwd_data_o
);

    wb_stage_t stage;
    logic      committed;   // the held entry has already been written
    WORD       load_data;
    logic      write_en;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stage     <= '0;
            committed <= 1'b0;
        end else if (flush_i) begin
            // A bubble keeps the old address and data; only the write is killed.
            stage.we  <= WRITE_DISABLE;
            committed <= 1'b0;
        end else if (!stall_i) begin
            stage.we   <= reg_file_write_en_i;
            stage.src  <= reg_file_input_ctrl_sig_i;
            stage.addr <= reg_dest_addr_i;
            stage.alu  <= alu_result_i;
            stage.mem  <= mem_data_i;
            stage.size <= mem_access_size_i;
            stage.sgn  <= mem_signed_i;
            stage.low  <= mem_addr_low_i;
            committed  <= 1'b0;
        end else if (write_en) begin
            // Stalled: the entry is written once, then suppressed while held.
            committed <= 1'b1;
        end
    end

    load_extender u_load_extender (
        .mem_data_i (stage.mem),
        .size_i     (stage.size),
        .signed_i   (stage.sgn),
        .addr_low_i (stage.low),
        .data_o     (load_data)
    );

    assign write_en            = (stage.we == WRITE_ENABLE) && !committed;
    assign reg_file_write_en_o = write_en;
    assign reg_dest_addr_o     = stage.addr;
    assign reg_data_o          = (stage.src == FROM_MEM) ? load_data : stage.alu;

`ifdef WB_FORWARD_HISTORY_EN
    logic                  hist_valid;
    logic [ADDR_WIDTH-1:0] hist_addr;
    WORD                   hist_data;

    // Address and data hold across cycles with no write; only valid drops.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hist_valid <= 1'b0;
            hist_addr  <= '0;
            hist_data  <= '0;
        end else if (write_en) begin
            hist_valid <= 1'b1;
            hist_addr  <= stage.addr;
            hist_data  <= reg_data_o;
        end else begin
            hist_valid <= 1'b0;
        end
    end

    assign fwd_valid_o = hist_valid;
    assign fwd_addr_o  = hist_addr;
    assign fwd_data_o  = hist_data;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_addr_o  = '0;
    assign fwd_data_o  = '0;
`endif

endmodule
